// File: rtl/ibex_multdiv_issue.sv
// Issues RV32M ops to the slow multdiv, holds operands/imd values and writes back results.
// Latency: en one cycle after issue; writeback same cycle as valid_i & wb_ready_i, stalls on !wb_ready_i.
module ibex_multdiv_issue #(
  parameter int unsigned RdAddrW = 5,
  parameter int unsigned CntW    = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  input  logic [2:0]         funct3_i,
  input  logic [31:0]        rs1_i,
  input  logic [31:0]        rs2_i,
  input  logic [RdAddrW-1:0] rd_i,
  input  logic               flush_i,
  input  logic               data_ind_timing_i,
  output logic               mult_en_o,
  output logic               div_en_o,
  output logic               mult_sel_o,
  output logic               div_sel_o,
  output logic [1:0]         operator_o,
  output logic [1:0]         signed_mode_o,
  output logic [31:0]        op_a_o,
  output logic [31:0]        op_b_o,
  output logic               data_ind_timing_o,
  input  logic [33:0]        imd_val_d_i [2],
  input  logic [1:0]         imd_val_we_i,
  output logic [33:0]        imd_val_q_o [2],
  output logic               multdiv_ready_id_o,
  input  logic               valid_i,
  input  logic [31:0]        result_i,
  input  logic               wb_ready_i,
  output logic               rf_we_o,
  output logic [RdAddrW-1:0] rf_waddr_o,
  output logic [31:0]        rf_wdata_o,
  output logic [CntW-1:0]    done_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] MD_OP_MULL = 2'd0;
  localparam logic [1:0] MD_OP_MULH = 2'd1;
  localparam logic [1:0] MD_OP_DIV  = 2'd2;
  localparam logic [1:0] MD_OP_REM  = 2'd3;

  state_e             state_q;
  logic               instr_ready_q;
  logic               mult_act_q;
  logic               div_act_q;
  logic [1:0]         operator_q;
  logic [1:0]         signed_mode_q;
  logic [31:0]        op_a_q;
  logic [31:0]        op_b_q;
  logic [RdAddrW-1:0] rd_q;
  logic               data_ind_timing_q;
  logic [CntW-1:0]    done_cnt_q;
  logic [33:0]        imd_val_q [2];

  logic [1:0] dec_operator;
  logic [1:0] dec_signed_mode;
  logic       wb_fire;

  always_comb begin
    dec_operator    = MD_OP_MULL;
    dec_signed_mode = 2'b00;
    unique case (funct3_i)
      3'b000: begin dec_operator = MD_OP_MULL; dec_signed_mode = 2'b11; end
      3'b001: begin dec_operator = MD_OP_MULH; dec_signed_mode = 2'b11; end
      3'b010: begin dec_operator = MD_OP_MULH; dec_signed_mode = 2'b01; end
      3'b011: begin dec_operator = MD_OP_MULH; dec_signed_mode = 2'b00; end
      3'b100: begin dec_operator = MD_OP_DIV;  dec_signed_mode = 2'b11; end
      3'b101: begin dec_operator = MD_OP_DIV;  dec_signed_mode = 2'b00; end
      3'b110: begin dec_operator = MD_OP_REM;  dec_signed_mode = 2'b11; end
      default: begin dec_operator = MD_OP_REM; dec_signed_mode = 2'b00; end
    endcase
  end

  // A flush in the same cycle as a ready result squashes the write.
  assign wb_fire = (state_q == BUSY) && valid_i && wb_ready_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= IDLE;
      instr_ready_q     <= 1'b1;
      mult_act_q        <= 1'b0;
      div_act_q         <= 1'b0;
      operator_q        <= 2'd0;
      signed_mode_q     <= 2'd0;
      op_a_q            <= 32'd0;
      op_b_q            <= 32'd0;
      rd_q              <= '0;
      data_ind_timing_q <= 1'b0;
      done_cnt_q        <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (instr_valid_i) begin
            state_q           <= BUSY;
            instr_ready_q     <= 1'b0;
            mult_act_q        <= ~funct3_i[2];
            div_act_q         <= funct3_i[2];
            operator_q        <= dec_operator;
            signed_mode_q     <= dec_signed_mode;
            op_a_q            <= rs1_i;
            op_b_q            <= rs2_i;
            rd_q              <= rd_i;
            data_ind_timing_q <= data_ind_timing_i;
          end
        end
        BUSY: begin
          if (flush_i) begin
            state_q <= DRAIN;
          end else if (valid_i && wb_ready_i) begin
            state_q       <= IDLE;
            instr_ready_q <= 1'b1;
            mult_act_q    <= 1'b0;
            div_act_q     <= 1'b0;
            done_cnt_q    <= done_cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          // Enables stay up until the multdiv returns to idle on its own.
          if (valid_i) begin
            state_q       <= IDLE;
            instr_ready_q <= 1'b1;
            mult_act_q    <= 1'b0;
            div_act_q     <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          instr_ready_q <= 1'b1;
          mult_act_q    <= 1'b0;
          div_act_q     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      imd_val_q[0] <= 34'd0;
      imd_val_q[1] <= 34'd0;
    end else begin
      if (imd_val_we_i[0]) imd_val_q[0] <= imd_val_d_i[0];
      if (imd_val_we_i[1]) imd_val_q[1] <= imd_val_d_i[1];
    end
  end

  assign instr_ready_o     = instr_ready_q;
  assign mult_en_o         = mult_act_q;
  assign div_en_o          = div_act_q;
  assign mult_sel_o        = mult_act_q;
  assign div_sel_o         = div_act_q;
  assign operator_o        = operator_q;
  assign signed_mode_o     = signed_mode_q;
  assign op_a_o            = op_a_q;
  assign op_b_o            = op_b_q;
  assign data_ind_timing_o = data_ind_timing_q;
  assign imd_val_q_o[0]    = imd_val_q[0];
  assign imd_val_q_o[1]    = imd_val_q[1];
  assign done_cnt_o        = done_cnt_q;

  assign multdiv_ready_id_o = (state_q == BUSY)  ? wb_ready_i :
                              (state_q == DRAIN) ? 1'b1 : 1'b0;
  assign rf_we_o    = wb_fire;
  assign rf_waddr_o = rd_q;
  assign rf_wdata_o = result_i;

endmodule

// File: doc/ibex_multdiv_issue.md
Name: ibex_multdiv_issue

Overview:
Issue-side controller for the slow multiplier/divider, sitting in the ID stage. It accepts RV32M instructions from the decoder and decodes funct3 into operator and signed mode. It drives the multdiv enable, select and ready handshakes, owns the two 34-bit intermediate-value registers shared with the multdiv/ALU path, and writes results back to the register file under backpressure. It also drains the multdiv cleanly after a pipeline flush.

Parameters:
RdAddrW, 5, destination register address width
CntW, 16, width of the completed-operation counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is synchronous and active-high
instr_valid_i  in  1  decoder presents an RV32M instruction
instr_ready_o  out  1  controller can accept an instruction
funct3_i  in  3  RV32M funct3
rs1_i  in  32  operand A
rs2_i  in  32  operand B
rd_i  in  RdAddrW  destination register
flush_i  in  1  squash the in-flight operation
data_ind_timing_i  in  1  data-independent timing request, sampled at issue
mult_en_o  out  1  multdiv dynamic enable, mult
div_en_o  out  1  multdiv dynamic enable, div
mult_sel_o  out  1  multdiv static select, mult
div_sel_o  out  1  multdiv static select, div
operator_o  out  2  MULL=0, MULH=1, DIV=2, REM=3
signed_mode_o  out  2  bit0 = A signed, bit1 = B signed
op_a_o  out  32  held operand A
op_b_o  out  32  held operand B
data_ind_timing_o  out  1  held timing mode
imd_val_d_i  in  2x34  next intermediate values from multdiv
imd_val_we_i  in  2  per-register write enables
imd_val_q_o  out  2x34  intermediate-value registers
multdiv_ready_id_o  out  1  ID can consume the result
valid_i  in  1  multdiv result valid
result_i  in  32  multdiv result
wb_ready_i  in  1  writeback port accepts
rf_we_o  out  1  register-file write strobe
rf_waddr_o  out  RdAddrW  write address
rf_wdata_o  out  32  write data
done_cnt_o  out  CntW  completed (written-back) operation count

Behaviour:
- funct3 decode (operator, signed_mode):
  - 000 MUL: MULL, 11
  - 001 MULH: MULH, 11
  - 010 MULHSU: MULH, 01
  - 011 MULHU: MULH, 00
  - 100 DIV: DIV, 11
  - 101 DIVU: DIV, 00
  - 110 REM: REM, 11
  - 111 REMU: REM, 00
  - mult = funct3[2]==0; div otherwise.
- States: IDLE, BUSY, DRAIN.
- IDLE:
  - instr_ready_o=1; all en/sel outputs 0.
  - instr_valid_i captures funct3 decode, rs1, rs2, rd and data_ind_timing_i into holding registers, then goes to BUSY.
  - flush_i in IDLE is ignored.
- BUSY:
  - instr_ready_o=0.
  - sel and en asserted for the captured class (mult or div), from the first cycle after issue. Issue-to-en latency is 1 cycle.
  - multdiv_ready_id_o = wb_ready_i.
  - valid_i & wb_ready_i: rf_we_o=1 in the same cycle, rf_wdata_o=result_i, rf_waddr_o=held rd; done_cnt_o increments; next state IDLE.
  - valid_i & !wb_ready_i: stay in BUSY, rf_we_o=0. The multdiv holds its result until wb_ready_i rises.
- flush_i in BUSY:
  - Takes priority over writeback in the same cycle: no rf_we_o, no increment.
  - Next state is DRAIN.
- DRAIN:
  - en/sel kept asserted so the multdiv FSM reaches idle; multdiv_ready_id_o=1; rf_we_o=0.
  - valid_i moves to IDLE.
  - Further flush_i is ignored; instr_ready_o=0.
- Back-to-back issue: minimum one IDLE cycle between writeback and the next accept.
- Operands, operator and signed_mode are held stable from issue until leaving BUSY/DRAIN.
- imd_val_q_o[i] loads imd_val_d_i[i] whenever imd_val_we_i[i]=1, in any state. The two registers are independent.
- done_cnt_o wraps modulo 2^CntW.
- Reset (rst_i=1 at a clock edge, including mid-operation):
  - State goes to IDLE.
  - Held operands, rd and operator reset to 0; imd_val_q_o reset to 0; done_cnt_o resets to 0.
  - All en/sel, rf_we_o and multdiv_ready_id_o outputs are 0; instr_ready_o=1 after reset.
  - The multdiv must be reset by the same rst_i.

Test Plan:
- Issue MUL rs1=7, rs2=6; multdiv returns valid_i with result 42, wb_ready_i=1 -> mult_en_o=1 from cycle after issue, operator_o=0, signed_mode_o=11; one rf_we_o pulse, rf_wdata_o=42, rf_waddr_o=rd; done_cnt_o=1.
- Issue DIVU rs1=0x80000000, rs2=0 -> div_en_o=1, operator_o=2, signed_mode_o=00; when result 0xFFFFFFFF is valid it is written once.
- Issue MULHSU with wb_ready_i=0 for 5 cycles after valid_i -> multdiv_ready_id_o=0 and rf_we_o=0 throughout; on wb_ready_i=1 exactly one write, then IDLE.
- Issue REM, assert flush_i mid-operation -> DRAIN with div_en_o still 1; on valid_i no rf_we_o, return to IDLE, done_cnt_o unchanged; next instruction is accepted normally.
- Assert rst_i while in BUSY -> next cycle instr_ready_o=1, all en/sel=0, imd_val_q_o=0, done_cnt_o=0.
- imd_val_we_i=01 with d[0]=0x3_0000_0001 -> only imd_val_q_o[0] updates; imd_val_q_o[1] is unchanged.
